// File: rtl/v_alu_mdu_pkg.sv
// Shared opcodes, FSM states and flag payload for the EX-stage ALU/MDU.
package v_alu_mdu_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'd0,
                         ALU_SUB  = 4'd1,
                         ALU_AND  = 4'd2,
                         ALU_OR   = 4'd3,
                         ALU_XOR  = 4'd4,
                         ALU_SLL  = 4'd5,
                         ALU_SRL  = 4'd6,
                         ALU_SRA  = 4'd7,
                         ALU_SLT  = 4'd8,
                         ALU_SLTU = 4'd9;

  localparam logic [2:0] MOP_MUL    = 3'd0,
                         MOP_MULH   = 3'd1,
                         MOP_MULHSU = 3'd2,
                         MOP_MULHU  = 3'd3,
                         MOP_DIV    = 3'd4,
                         MOP_DIVU   = 3'd5,
                         MOP_REM    = 3'd6,
                         MOP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  // Operand A is treated as signed for these M-ops.
  function automatic logic a_is_signed(input logic [2:0] mop);
    return (mop == MOP_MULH) || (mop == MOP_MULHSU) || (mop == MOP_DIV) || (mop == MOP_REM);
  endfunction

  // Operand B is treated as signed for these M-ops.
  function automatic logic b_is_signed(input logic [2:0] mop);
    return (mop == MOP_MULH) || (mop == MOP_DIV) || (mop == MOP_REM);
  endfunction

endpackage

// File: rtl/v_alu_mdu_if.sv
// Request/response bus between the pipeline and the ALU/MDU.
interface v_alu_mdu_if #(parameter int unsigned WIDTH = 32);
  import v_alu_mdu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             Z;
  logic             N;
  logic             C;
  logic             V;
  logic             busy;

  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, result, Z, N, C, V, busy
  );

  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, result, Z, N, C, V, busy
  );
endinterface

// File: rtl/v_alu_mdu_iter.sv
// Iterative one-bit-per-cycle datapath: shift-add multiply and restoring divide
// on unsigned magnitudes. Sign handling lives in the parent.
module v_mdu_iter
  import v_alu_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic             run_q;
  logic             div_q;
  logic             done_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] d_q;

  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   rem_sh_c;
  logic             ge_c;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;

  // One step: hi:lo is accumulator:multiplier for MUL, remainder:quotient for DIV.
  always_comb begin
    sum_c    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : {(WIDTH+1){1'b0}});
    rem_sh_c = {hi_q, lo_q[WIDTH-1]};
    ge_c     = rem_sh_c >= {1'b0, d_q};
    if (div_q) begin
      hi_d = ge_c ? WIDTH'(rem_sh_c - {1'b0, d_q}) : rem_sh_c[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ge_c};
    end else begin
      hi_d = sum_c[WIDTH:1];
      lo_d = {sum_c[0], lo_q[WIDTH-1:1]};
    end
  end

  // done marks the cycle in which the final iteration is being performed.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= 1'b0;
      div_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      d_q    <= '0;
    end else if (start) begin
      run_q  <= 1'b1;
      div_q  <= is_div;
      done_q <= 1'b0;
      cnt_q  <= SHW'(WIDTH - 1);
      hi_q   <= '0;
      lo_q   <= a_mag;
      d_q    <= b_mag;
    end else if (run_q) begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      cnt_q  <= cnt_q - SHW'(1);
      done_q <= (cnt_q == SHW'(1));
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/v_alu_mdu.sv
// Handshaked EX-stage ALU with registered base ops (latency 1) and an
// iterative RV-M multiply/divide unit behind the same output register.
module v_alu_mdu
  import v_alu_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  v_alu_mdu_if.slave   bus
);

  localparam int unsigned    SHW     = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES    = '1;

  state_t state, next_state;

  logic [2:0]       mop_q;
  logic             sa_q;
  logic             sb_q;
  logic [WIDTH-1:0] result_q;
  flags_t           flags_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             in_ready_c;
  logic             accept_c;
  logic             start_c;
  logic             load_c;
  logic [WIDTH-1:0] res_d;
  logic             c_d;
  logic             v_d;
  flags_t           flags_d;

  logic             is_m_c;
  logic [2:0]       mop_c;
  logic             sa_c;
  logic             sb_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic             b_zero_c;
  logic             ovf_c;
  logic             special_c;
  logic [WIDTH-1:0] special_res_c;

  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   diff_c;
  logic [SHW-1:0]   shamt_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_c_c;
  logic             alu_v_c;

  logic             it_done;
  logic [WIDTH-1:0] it_hi;
  logic [WIDTH-1:0] it_lo;
  logic [2*WIDTH-1:0] prod_c;
  logic [2*WIDTH-1:0] prod_fix_c;
  logic [WIDTH-1:0] quot_fix_c;
  logic [WIDTH-1:0] rem_fix_c;
  logic [WIDTH-1:0] mdu_res_c;

  assign in_ready_c = !rst && (state == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept_c   = bus.in_valid && in_ready_c;

  // Operand decode for M-ops; magnitudes feed the iterative datapath.
  assign is_m_c   = bus.op[4];
  assign mop_c    = bus.op[2:0];
  assign sa_c     = a_is_signed(mop_c) & bus.A[WIDTH-1];
  assign sb_c     = b_is_signed(mop_c) & bus.B[WIDTH-1];
  assign a_mag_c  = sa_c ? -bus.A : bus.A;
  assign b_mag_c  = sb_c ? -bus.B : bus.B;
  assign b_zero_c = (bus.B == '0);
  assign ovf_c    = ((mop_c == MOP_DIV) || (mop_c == MOP_REM)) &&
                    (bus.A == MIN_VAL) && (bus.B == ONES);
  assign special_c = mop_c[2] && (b_zero_c || ovf_c);

  // mop[1] separates REM* from DIV* among the divide codes.
  always_comb begin
    if (b_zero_c) begin
      special_res_c = mop_c[1] ? bus.A : ONES;
    end else begin
      special_res_c = mop_c[1] ? '0 : MIN_VAL;
    end
  end

  // Base ALU.
  always_comb begin
    alu_res_c = '0;
    alu_c_c   = 1'b0;
    alu_v_c   = 1'b0;
    sum_c     = {1'b0, bus.A} + {1'b0, bus.B};
    diff_c    = {1'b0, bus.A} - {1'b0, bus.B};
    shamt_c   = bus.B[SHW-1:0];
    case (bus.op[3:0])
      ALU_ADD: begin
        alu_res_c = sum_c[WIDTH-1:0];
        alu_c_c   = sum_c[WIDTH];
        alu_v_c   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_c[WIDTH-1] != bus.A[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res_c = diff_c[WIDTH-1:0];
        alu_c_c   = ~diff_c[WIDTH];
        alu_v_c   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff_c[WIDTH-1] != bus.A[WIDTH-1]);
      end
      ALU_AND:  alu_res_c = bus.A & bus.B;
      ALU_OR:   alu_res_c = bus.A | bus.B;
      ALU_XOR:  alu_res_c = bus.A ^ bus.B;
      ALU_SLL:  alu_res_c = bus.A << shamt_c;
      ALU_SRL:  alu_res_c = bus.A >> shamt_c;
      ALU_SRA:  alu_res_c = $signed(bus.A) >>> shamt_c;
      ALU_SLT:  alu_res_c = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      ALU_SLTU: alu_res_c = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      default:  alu_res_c = '0;
    endcase
  end

  v_mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start_c),
    .is_div (mop_c[2]),
    .a_mag  (a_mag_c),
    .b_mag  (b_mag_c),
    .done   (it_done),
    .hi     (it_hi),
    .lo     (it_lo)
  );

  // Sign fix-up of the raw magnitude result, using the signs latched at accept.
  always_comb begin
    prod_c     = {it_hi, it_lo};
    prod_fix_c = (sa_q ^ sb_q) ? -prod_c : prod_c;
    quot_fix_c = (sa_q ^ sb_q) ? -it_lo : it_lo;
    rem_fix_c  = sa_q ? -it_hi : it_hi;
    case (mop_q)
      MOP_MUL:                        mdu_res_c = prod_fix_c[WIDTH-1:0];
      MOP_MULH, MOP_MULHSU, MOP_MULHU: mdu_res_c = prod_fix_c[2*WIDTH-1:WIDTH];
      MOP_DIV, MOP_DIVU:              mdu_res_c = quot_fix_c;
      default:                        mdu_res_c = rem_fix_c;
    endcase
  end

  // Next-state and output-load decisions.
  always_comb begin
    next_state = state;
    load_c     = 1'b0;
    start_c    = 1'b0;
    res_d      = '0;
    c_d        = 1'b0;
    v_d        = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          if (!is_m_c) begin
            load_c = 1'b1;
            res_d  = alu_res_c;
            c_d    = alu_c_c;
            v_d    = alu_v_c;
          end else if (special_c) begin
            load_c = 1'b1;
            res_d  = special_res_c;
          end else begin
            start_c    = 1'b1;
            next_state = mop_c[2] ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (it_done) begin
          next_state = S_FIN;
        end
      end
      S_FIN: begin
        load_c     = 1'b1;
        res_d      = mdu_res_c;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    flags_d.z = (res_d == '0);
    flags_d.n = res_d[WIDTH-1];
    flags_d.c = c_d;
    flags_d.v = v_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Output register holds while the consumer stalls; busy tracks the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mop_q       <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
    end else begin
      busy_q      <= (next_state != S_IDLE);
      out_valid_q <= load_c | (out_valid_q & ~bus.out_ready);
      if (load_c) begin
        result_q <= res_d;
        flags_q  <= flags_d;
      end
      if (start_c) begin
        mop_q <= mop_c;
        sa_q  <= sa_c;
        sb_q  <= sb_c;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.Z         = flags_q.z;
  assign bus.N         = flags_q.n;
  assign bus.C         = flags_q.c;
  assign bus.V         = flags_q.v;
  assign bus.busy      = busy_q;

endmodule
